// File: rtl/cht_shift_sequencer_pkg.sv
// Shared types for the shift/hold datapath sequencer: command opcodes, FSM
// states and the queued command record.
package cht_seq_pkg;

  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_CLEAR = 2'b01,
    OP_SHL   = 2'b10,
    OP_SHR   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLR   = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // The amount field width follows the sequencer's default CNT_W.
  typedef struct packed {
    op_e                  op;
    logic [CNT_W_DEF-1:0] amt;
  } cmd_t;

endpackage

// File: rtl/cht_shift_sequencer_if.sv
// Command channel into the sequencer. valid/ready: a command transfers on a
// rising clk edge where cmd_valid && cmd_ready; the source holds op/amt stable
// while cmd_valid is high and not yet accepted.
interface cht_shift_sequencer_if
  import cht_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [CNT_W-1:0] cmd_amt;

  modport master (output cmd_valid, output cmd_op, output cmd_amt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_amt, output cmd_ready);

endinterface

// File: rtl/cht_cmd_fifo.sv
// Small synchronous command FIFO with a flush input; pointers and occupancy are
// reset asynchronously, storage is not reset.
module cht_cmd_fifo
  import cht_seq_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cht_shift_sequencer.sv
// Expands queued shift/clear commands into one-hot per-cycle datapath strobes
// and reports completion with a one-cycle done pulse.
module cht_shift_sequencer
  import cht_seq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  cht_shift_sequencer_if.slave  cmd,
  input  logic                  abort,
  output logic                  dp_clr,
  output logic                  dp_shl,
  output logic                  dp_shr,
  output logic                  busy,
  output logic                  done,
  output logic                  done_aborted,
  output logic [CNT_W-1:0]      strobe_cnt,
  output state_e                dbg_state
);

  state_e           state, state_d;
  op_e              dir_q, dir_d;
  logic [CNT_W-1:0] rem, rem_d, cnt_d;
  logic             ab_q, ab_d;
  logic             pop, full, empty;
  cmd_t             head, wcmd;

  assign wcmd.op  = cmd.cmd_op;
  assign wcmd.amt = cmd.cmd_amt;

  // Ready is forced low during reset; a push coinciding with abort is dropped.
  assign cmd.cmd_ready = ~rst & ~full;

  cht_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (cmd.cmd_valid & ~full & ~abort),
    .pop   (pop),
    .wdata (wcmd),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      dir_q      <= OP_NOP;
      rem        <= '0;
      strobe_cnt <= '0;
      ab_q       <= 1'b0;
    end else begin
      state      <= state_d;
      dir_q      <= dir_d;
      rem        <= rem_d;
      strobe_cnt <= cnt_d;
      ab_q       <= ab_d;
    end
  end

  always_comb begin
    state_d = state;
    dir_d   = dir_q;
    rem_d   = rem;
    cnt_d   = strobe_cnt;
    ab_d    = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        // The queue is being flushed by abort, so nothing is started from it.
        if (!empty && !abort) begin
          pop = 1'b1;
          case (head.op)
            OP_CLEAR: state_d = S_CLR;
            OP_SHL, OP_SHR: begin
              cnt_d = '0;
              dir_d = head.op;
              if (head.amt != '0) begin
                rem_d   = head.amt;
                state_d = S_SHIFT;
              end else begin
                state_d = S_DONE;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_CLR: begin
        state_d = S_DONE;
        ab_d    = abort;
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_DONE;
          ab_d    = 1'b1;
        end else begin
          rem_d = rem - CNT_W'(1);
          cnt_d = strobe_cnt + CNT_W'(1);
          if (rem == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dp_clr       = (state == S_CLR) & ~abort;
  assign dp_shl       = (state == S_SHIFT) & (dir_q == OP_SHL) & ~abort;
  assign dp_shr       = (state == S_SHIFT) & (dir_q == OP_SHR) & ~abort;
  assign done         = (state == S_DONE);
  assign done_aborted = done & ab_q;
  assign busy         = (state != S_IDLE) | ~empty;
  assign dbg_state    = state;

endmodule

// File: tb/tb_cht_shift_sequencer.sv
// Bench for cht_shift_sequencer: directed latency scenarios plus random
// traffic, all compared each cycle against a command/schedule model.
module tb_cht_shift_sequencer;
  import cht_seq_pkg::*;

  localparam int CNT_W = 5;
  localparam int DEPTH = 2;
  localparam int OW    = CNT_W + 7;
  localparam int K_SHL = 0, K_SHR = 1, K_CLR = 2, K_DONE = 3;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic             dp_clr, dp_shl, dp_shr, busy, done, done_aborted;
  logic [CNT_W-1:0] strobe_cnt;
  state_e           dbg_state;
  int               cyc = 0;

  cht_shift_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();

  cht_shift_sequencer #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_if),
    .abort        (abort),
    .dp_clr       (dp_clr),
    .dp_shl       (dp_shl),
    .dp_shr       (dp_shr),
    .busy         (busy),
    .done         (done),
    .done_aborted (done_aborted),
    .strobe_cnt   (strobe_cnt),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Commands waiting in the queue, and the list of per-cycle actions the
  // command in flight still has to perform (head = this cycle).
  typedef struct { int op; int amt; } mcmd_t;
  typedef struct { int kind; bit ab; } pitem_t;
  mcmd_t  mq[$];
  pitem_t plan[$];
  int     m_cnt;
  bit     model_on = 1'b0;

  function automatic logic [OW-1:0] model_outputs();
    logic rdy, clr, shl, shr, bsy, dn, dab;
    rdy = (mq.size() < DEPTH);
    bsy = (plan.size() != 0) || (mq.size() != 0);
    clr = 1'b0; shl = 1'b0; shr = 1'b0; dn = 1'b0; dab = 1'b0;
    if (plan.size() != 0) begin
      case (plan[0].kind)
        K_SHL:   shl = !abort;
        K_SHR:   shr = !abort;
        K_CLR:   clr = !abort;
        default: begin dn = 1'b1; dab = plan[0].ab; end
      endcase
    end
    return {rdy, clr, shl, shr, bsy, dn, dab, CNT_W'(m_cnt)};
  endfunction

  task automatic model_step();
    bit    pushed;
    mcmd_t c;
    pushed = cmd_if.cmd_valid && (mq.size() < DEPTH) && !abort;
    if (abort) begin
      mq.delete();
      if (plan.size() != 0 && plan[0].kind != K_DONE) begin
        plan.delete();
        plan.push_back('{kind: K_DONE, ab: 1'b1});
      end else if (plan.size() != 0) begin
        void'(plan.pop_front());
      end
    end else if (plan.size() == 0) begin
      if (mq.size() != 0) begin
        c = mq.pop_front();
        if (c.op == 1) plan.push_back('{kind: K_CLR, ab: 1'b0});
        if (c.op >= 2) begin
          m_cnt = 0;
          for (int k = 0; k < c.amt; k++)
            plan.push_back('{kind: (c.op == 2) ? K_SHL : K_SHR, ab: 1'b0});
        end
        plan.push_back('{kind: K_DONE, ab: 1'b0});
      end
    end else begin
      if (plan[0].kind == K_SHL || plan[0].kind == K_SHR) m_cnt++;
      void'(plan.pop_front());
    end
    if (pushed) mq.push_back('{op: int'(cmd_if.cmd_op), amt: int'(cmd_if.cmd_amt)});
  endtask

  task automatic model_reset();
    mq.delete();
    plan.delete();
    m_cnt = 0;
  endtask

  // ---------------- compare process + event log ----------------
  int shl_c[$], shr_c[$], clr_c[$], done_c[$], rdy_lo_c[$];
  int n_dab = 0;
  logic [OW-1:0] act_v;

  always @(negedge clk) begin
    if (!rst && model_on) begin
      exp_q.push_back(model_outputs());
      act_v = {cmd_if.cmd_ready, dp_clr, dp_shl, dp_shr, busy, done, done_aborted, strobe_cnt};
      check("cycle_outputs", 64'(act_v), 64'(exp_q.pop_front()));
      if (dp_shl) shl_c.push_back(cyc + 1);
      if (dp_shr) shr_c.push_back(cyc + 1);
      if (dp_clr) clr_c.push_back(cyc + 1);
      if (done) done_c.push_back(cyc + 1);
      if (done && done_aborted) n_dab++;
      if (!cmd_if.cmd_ready) rdy_lo_c.push_back(cyc + 1);
      model_step();
    end
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    shl_c.delete(); shr_c.delete(); clr_c.delete(); done_c.delete(); rdy_lo_c.delete();
    n_dab = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge
  // with cmd_valid still high.
  task automatic send(input int op, input int amt, output int t_acc);
    int   guard;
    logic ok;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op_e'(op[1:0]);
    cmd_if.cmd_amt   = amt[CNT_W-1:0];
    guard = 0;
    while (1) begin
      @(negedge clk);
      ok = cmd_if.cmd_ready;
      @(posedge clk);
      if (ok) break;
      guard++;
      if (guard > 50) begin
        check("send_timeout", 64'(guard), 64'(0));
        break;
      end
    end
    #1;
    t_acc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int   t, t2;
  logic took;

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = OP_NOP;
    cmd_if.cmd_amt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({cmd_if.cmd_ready, dp_clr, dp_shl, dp_shr, busy, done,
                                done_aborted, strobe_cnt}), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    model_on = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(cmd_if.cmd_ready), 64'(1));

    // 1: SHIFT_L 3
    clear_log();
    send(2, 3, t);
    cmd_if.cmd_valid = 1'b0;
    wait_idle();
    check("t1_shl_count", 64'(shl_c.size()), 64'(3));
    check("t1_shl_first", 64'(qat(shl_c, 0)), 64'(t + 2));
    check("t1_shl_last", 64'(qat(shl_c, 2)), 64'(t + 4));
    check("t1_done_cycle", 64'(qat(done_c, 0)), 64'(t + 5));
    check("t1_strobe_cnt", 64'(strobe_cnt), 64'(3));
    check("t1_no_abort", 64'(n_dab), 64'(0));

    // 2: CLEAR (strobe_cnt keeps 3)
    clear_log();
    send(1, 7, t);
    cmd_if.cmd_valid = 1'b0;
    wait_idle();
    check("t2_clr_count", 64'(clr_c.size()), 64'(1));
    check("t2_clr_cycle", 64'(qat(clr_c, 0)), 64'(t + 2));
    check("t2_done_cycle", 64'(qat(done_c, 0)), 64'(t + 3));
    check("t2_no_shift", 64'(shl_c.size() + shr_c.size()), 64'(0));
    check("t2_cnt_held", 64'(strobe_cnt), 64'(3));

    // 3: SHIFT_R 0
    clear_log();
    send(3, 0, t);
    cmd_if.cmd_valid = 1'b0;
    wait_idle();
    check("t3_no_strobes", 64'(shl_c.size() + shr_c.size() + clr_c.size()), 64'(0));
    check("t3_done_cycle", 64'(qat(done_c, 0)), 64'(t + 2));
    check("t3_strobe_cnt", 64'(strobe_cnt), 64'(0));

    // 4: SHL 2, SHR 1, CLEAR back to back
    clear_log();
    send(2, 2, t);
    send(3, 1, t2);
    send(1, 0, t2);
    cmd_if.cmd_valid = 1'b0;
    wait_idle();
    check("t4_shl", 64'({qat(shl_c, 0), qat(shl_c, 1)}), 64'({t + 2, t + 3}));
    check("t4_shr", 64'(qat(shr_c, 0)), 64'(t + 6));
    check("t4_clr", 64'(qat(clr_c, 0)), 64'(t + 9));
    check("t4_done_count", 64'(done_c.size()), 64'(3));
    check("t4_done_cycles", 64'({qat(done_c, 0), qat(done_c, 1)}), 64'({t + 4, t + 7}));
    check("t4_done_last", 64'(qat(done_c, 2)), 64'(t + 10));
    check("t4_ready_low", 64'({rdy_lo_c.size(), qat(rdy_lo_c, 0)}), 64'({3, t + 3}));

    // 5: SHIFT_R 5 aborted at its 2nd strobe with one command queued
    clear_log();
    send(3, 5, t);
    send(2, 4, t2);
    cmd_if.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_idle();
    check("t5_shr_count", 64'(shr_c.size()), 64'(1));
    check("t5_done", 64'({done_c.size(), qat(done_c, 0)}), 64'({1, t + 4}));
    check("t5_aborted", 64'(n_dab), 64'(1));
    check("t5_strobe_cnt", 64'(strobe_cnt), 64'(1));
    check("t5_flushed", 64'({shl_c.size(), busy}), 64'(0));

    // 6: reset in the middle of SHIFT_L 8
    clear_log();
    send(2, 8, t);
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("t6_shl_before", 64'(dp_shl), 64'(1));
    rst = 1'b1;
    #1;
    check("t6_async_zero", 64'({cmd_if.cmd_ready, dp_clr, dp_shl, dp_shr, busy, done,
                                done_aborted, strobe_cnt}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("t6_ready_after", 64'(cmd_if.cmd_ready), 64'(1));
    wait_idle();
    check("t6_no_done", 64'(done_c.size()), 64'(0));

    // Random traffic; the source holds a command until it is taken.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      took = cmd_if.cmd_valid && cmd_if.cmd_ready;
      @(posedge clk);
      #1;
      if (!cmd_if.cmd_valid || took) begin
        cmd_if.cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_if.cmd_op    = op_e'($urandom_range(0, 3));
        cmd_if.cmd_amt   = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 31))
                                                       : CNT_W'($urandom_range(0, 6));
      end
      abort = ($urandom_range(0, 39) == 0);
    end
    cmd_if.cmd_valid = 1'b0;
    abort = 1'b0;
    wait_idle();
    check("final_idle", 64'({busy, done}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
